// File: rtl/uart_stream_core_if.sv
// Fabric-side stream bundle for uart_stream_core: the TX stream (fabric -> core) and the
// first-word-fall-through RX stream (core -> fabric), which carries per-entry error flags.
interface uart_stream_core_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] TX_DATA;
    logic              TX_VALID;
    logic              TX_READY;
    logic [DATA_W-1:0] RX_DATA;
    logic              RX_PERR;
    logic              RX_FERR;
    logic              RX_VALID;
    logic              RX_READY;

    modport master (
        output TX_DATA, TX_VALID, RX_READY,
        input  TX_READY, RX_DATA, RX_PERR, RX_FERR, RX_VALID
    );

    modport slave (
        input  TX_DATA, TX_VALID, RX_READY,
        output TX_READY, RX_DATA, RX_PERR, RX_FERR, RX_VALID
    );
endinterface

// File: rtl/uart_stream_core.sv
// Full-duplex UART core: 16x baud tick generator, TX/RX frame engines with optional parity
// and two-stop-bit transmit, and one FIFO per direction (depth 2**FIFO_AW).
// RX FIFO entries carry {FERR, PERR, data}; a frame arriving at a full RX FIFO is dropped
// and flagged in the sticky OVERFLOW bit.
//
// state    | meaning
// S_IDLE   | line idle; TX waits for FIFO data, RX waits for a falling edge
// S_START  | start bit (RX checks mid-bit for a false start)
// S_DATA   | DATA_W data bits, LSB first
// S_PARITY | optional parity bit
// S_STOP   | stop bit(s); RX samples mid-bit and pushes the entry
// S_BREAK  | RX only: after a framing error, wait for the line to return high
module uart_stream_core #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [12:0]        BAUD_VAL,
    input  logic               PARITY_EN,
    input  logic               ODD_N_EVEN,
    input  logic               STOP2,
    uart_stream_core_if.slave  strm,
    output logic [FIFO_AW:0]   TX_LEVEL,
    output logic [FIFO_AW:0]   RX_LEVEL,
    output logic               OVERFLOW,
    input  logic               OVF_CLR,
    output logic               TX_BUSY,
    input  logic               RX,
    output logic               TX
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int RW    = DATA_W + 2;
    localparam logic [FIFO_AW:0]   LVL_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [3:0]         BCNT_LAST = 4'(DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    logic [12:0] baud_cnt_q, baud_cnt_d;
    logic        tick16;

    logic [DATA_W-1:0]  tx_mem_q [DEPTH];
    logic [DATA_W-1:0]  tx_mem_d [DEPTH];
    logic [FIFO_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [FIFO_AW:0]   tx_lvl_q, tx_lvl_d;
    logic               tx_push, tx_pop, tx_load, tx_bit_end;

    state_t             tx_state_q, tx_state_d;
    logic [DATA_W-1:0]  tx_sh_q, tx_sh_d;
    logic [3:0]         tx_tcnt_q, tx_tcnt_d, tx_bcnt_q, tx_bcnt_d;
    logic               tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_stop2_q, tx_stop2_d;
    logic               tx_q, tx_d;

    logic [RW-1:0]      rx_mem_q [DEPTH];
    logic [RW-1:0]      rx_mem_d [DEPTH];
    logic [FIFO_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [FIFO_AW:0]   rx_lvl_q, rx_lvl_d;
    logic               rx_push_req, rx_push, rx_pop, rx_drop;
    logic [RW-1:0]      rx_entry, rx_head;

    state_t             rx_state_q, rx_state_d;
    logic               rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [DATA_W-1:0]  rx_sh_q, rx_sh_d;
    logic [3:0]         rx_tcnt_q, rx_tcnt_d, rx_bcnt_q, rx_bcnt_d;
    logic               rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
    logic               rx_mid, rx_bit_end;
    logic               ovf_q, ovf_d;

    // Baud divider: free-running down-counter, tick16 on terminal count then reload.
    always_comb begin
        tick16     = (baud_cnt_q == 13'd0);
        baud_cnt_d = tick16 ? BAUD_VAL : baud_cnt_q - 13'd1;
    end

    // TX FIFO: push from the fabric stream, pop when the TX engine starts a frame.
    always_comb begin
        tx_push  = strm.TX_VALID && (tx_lvl_q != LVL_FULL);
        tx_mem_d = tx_mem_q;
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_lvl_d = tx_lvl_q;
        if (tx_push) begin
            tx_mem_d[tx_wp_q] = strm.TX_DATA;
            tx_wp_d           = tx_wp_q + PTR_ONE;
        end
        if (tx_pop) tx_rp_d = tx_rp_q + PTR_ONE;
        if (tx_push && !tx_pop)      tx_lvl_d = tx_lvl_q + LVL_ONE;
        else if (!tx_push && tx_pop) tx_lvl_d = tx_lvl_q - LVL_ONE;
    end

    // TX engine next state; frame config is latched on load so mid-frame changes are ignored.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_par_d   = tx_par_q;
        tx_pen_d   = tx_pen_q;
        tx_stop2_d = tx_stop2_q;
        tx_load    = 1'b0;
        tx_bit_end = tick16 && (tx_tcnt_q == 4'd15);
        if (tx_state_q != S_IDLE && tick16) tx_tcnt_d = tx_tcnt_q + 4'd1;
        case (tx_state_q)
            S_IDLE:   tx_load = (tx_lvl_q != '0);
            S_START:  if (tx_bit_end) tx_state_d = S_DATA;
            S_DATA: begin
                if (tx_bit_end) begin
                    tx_sh_d = tx_sh_q >> 1;
                    if (tx_bcnt_q == BCNT_LAST) begin
                        tx_bcnt_d  = 4'd0;
                        tx_state_d = tx_pen_q ? S_PARITY : S_STOP;
                    end else begin
                        tx_bcnt_d = tx_bcnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: if (tx_bit_end) tx_state_d = S_STOP;
            S_STOP: begin
                if (tx_bit_end) begin
                    if (tx_stop2_q && tx_bcnt_q == 4'd0) tx_bcnt_d = 4'd1;
                    else if (tx_lvl_q != '0)             tx_load   = 1'b1;
                    else                                 tx_state_d = S_IDLE;
                end
            end
            default:  tx_state_d = S_IDLE;
        endcase
        if (tx_load) begin
            tx_sh_d    = tx_mem_q[tx_rp_q];
            tx_par_d   = (^tx_mem_q[tx_rp_q]) ^ ODD_N_EVEN;
            tx_pen_d   = PARITY_EN;
            tx_stop2_d = STOP2;
            tx_tcnt_d  = 4'd0;
            tx_bcnt_d  = 4'd0;
            tx_state_d = S_START;
        end
        tx_pop = tx_load;
        case (tx_state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_sh_d[0];
            S_PARITY: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // RX engine next state: synchroniser, start detect, mid-bit sampling, entry build.
    always_comb begin
        rx_s1_d     = RX;
        rx_s2_d     = rx_s1_q;
        rx_prev_d   = rx_s2_q;
        rx_state_d  = rx_state_q;
        rx_sh_d     = rx_sh_q;
        rx_tcnt_d   = rx_tcnt_q;
        rx_bcnt_d   = rx_bcnt_q;
        rx_pen_d    = rx_pen_q;
        rx_odd_d    = rx_odd_q;
        rx_perr_d   = rx_perr_q;
        rx_push_req = 1'b0;
        rx_entry    = {!rx_s2_q, rx_perr_q, rx_sh_q};
        rx_mid      = tick16 && (rx_tcnt_q == 4'd7);
        rx_bit_end  = tick16 && (rx_tcnt_q == 4'd15);
        if (rx_state_q != S_IDLE && rx_state_q != S_BREAK && tick16) rx_tcnt_d = rx_tcnt_q + 4'd1;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_tcnt_d  = 4'd0;
                    rx_bcnt_d  = 4'd0;
                    rx_perr_d  = 1'b0;
                    rx_pen_d   = PARITY_EN;
                    rx_odd_d   = ODD_N_EVEN;
                end
            end
            S_START: begin
                if (rx_mid && rx_s2_q) rx_state_d = S_IDLE;
                else if (rx_bit_end)   rx_state_d = S_DATA;
            end
            S_DATA: begin
                if (rx_mid) rx_sh_d = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
                if (rx_bit_end) begin
                    if (rx_bcnt_q == BCNT_LAST) begin
                        rx_bcnt_d  = 4'd0;
                        rx_state_d = rx_pen_q ? S_PARITY : S_STOP;
                    end else begin
                        rx_bcnt_d = rx_bcnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_mid)     rx_perr_d  = rx_s2_q ^ (^rx_sh_q) ^ rx_odd_q;
                if (rx_bit_end) rx_state_d = S_STOP;
            end
            S_STOP: begin
                if (rx_mid) begin
                    rx_push_req = 1'b1;
                    rx_state_d  = rx_s2_q ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK:  if (rx_s2_q) rx_state_d = S_IDLE;
            default:  rx_state_d = S_IDLE;
        endcase
    end

    // RX FIFO: a push into a full FIFO is accepted only if the head is popped in the same cycle.
    always_comb begin
        rx_pop   = (rx_lvl_q != '0) && strm.RX_READY;
        rx_push  = rx_push_req && ((rx_lvl_q != LVL_FULL) || rx_pop);
        rx_drop  = rx_push_req && !rx_push;
        rx_mem_d = rx_mem_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_lvl_d = rx_lvl_q;
        if (rx_push) begin
            rx_mem_d[rx_wp_q] = rx_entry;
            rx_wp_d           = rx_wp_q + PTR_ONE;
        end
        if (rx_pop) rx_rp_d = rx_rp_q + PTR_ONE;
        if (rx_push && !rx_pop)      rx_lvl_d = rx_lvl_q + LVL_ONE;
        else if (!rx_push && rx_pop) rx_lvl_d = rx_lvl_q - LVL_ONE;
        ovf_d = (ovf_q && !OVF_CLR) || rx_drop;
    end

    // State registers with synchronous reset; reset also discards FIFO contents and partial frames.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            baud_cnt_q <= 13'd0;
            for (int i = 0; i < DEPTH; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_lvl_q   <= '0;
            tx_state_q <= S_IDLE;
            tx_sh_q    <= '0;
            tx_tcnt_q  <= 4'd0;
            tx_bcnt_q  <= 4'd0;
            tx_par_q   <= 1'b0;
            tx_pen_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            tx_q       <= 1'b1;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_lvl_q   <= '0;
            rx_state_q <= S_IDLE;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_sh_q    <= '0;
            rx_tcnt_q  <= 4'd0;
            rx_bcnt_q  <= 4'd0;
            rx_pen_q   <= 1'b0;
            rx_odd_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            tx_mem_q   <= tx_mem_d;
            rx_mem_q   <= rx_mem_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_lvl_q   <= tx_lvl_d;
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tx_par_q   <= tx_par_d;
            tx_pen_q   <= tx_pen_d;
            tx_stop2_q <= tx_stop2_d;
            tx_q       <= tx_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_lvl_q   <= rx_lvl_d;
            rx_state_q <= rx_state_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            rx_sh_q    <= rx_sh_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_pen_q   <= rx_pen_d;
            rx_odd_q   <= rx_odd_d;
            rx_perr_q  <= rx_perr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rx_head       = rx_mem_q[rx_rp_q];
    assign strm.TX_READY = (tx_lvl_q != LVL_FULL);
    assign strm.RX_VALID = (rx_lvl_q != '0);
    assign strm.RX_DATA  = strm.RX_VALID ? rx_head[DATA_W-1:0] : '0;
    assign strm.RX_PERR  = strm.RX_VALID && rx_head[DATA_W];
    assign strm.RX_FERR  = strm.RX_VALID && rx_head[DATA_W+1];
    assign TX_LEVEL      = tx_lvl_q;
    assign RX_LEVEL      = rx_lvl_q;
    assign OVERFLOW      = ovf_q;
    assign TX_BUSY       = (tx_state_q != S_IDLE);
    assign TX            = tx_q;
endmodule

// File: tb/tb_uart_stream_core.sv
// Directed bench for uart_stream_core: an 8-bit, depth-4 instance driven from the bench and a
// 7-bit instance with TX looped back to RX. BAUD_VAL=0 throughout, so one bit is 16 clocks.
module tb_uart_stream_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] baud;
    logic        pen, odd, stop2, ovf_clr, rx_drv;
    logic        tx8, busy8, ovf8;
    logic [2:0]  tx_lvl8, rx_lvl8;
    logic        tx7, busy7, ovf7;
    logic [4:0]  tx_lvl7, rx_lvl7;
    int          n_chk = 0;
    int          n_pass = 0;

    uart_stream_core_if #(.DATA_W(8)) if8 ();
    uart_stream_core_if #(.DATA_W(7)) if7 ();

    always #5 clk = ~clk;

    uart_stream_core #(.DATA_W(8), .FIFO_AW(2)) u_dut (
        .CLK(clk), .RESET(rst), .BAUD_VAL(baud), .PARITY_EN(pen), .ODD_N_EVEN(odd),
        .STOP2(stop2), .strm(if8.slave), .TX_LEVEL(tx_lvl8), .RX_LEVEL(rx_lvl8),
        .OVERFLOW(ovf8), .OVF_CLR(ovf_clr), .TX_BUSY(busy8), .RX(rx_drv), .TX(tx8)
    );

    uart_stream_core #(.DATA_W(7), .FIFO_AW(4)) u_loop (
        .CLK(clk), .RESET(rst), .BAUD_VAL(baud), .PARITY_EN(1'b1), .ODD_N_EVEN(1'b1),
        .STOP2(1'b0), .strm(if7.slave), .TX_LEVEL(tx_lvl7), .RX_LEVEL(rx_lvl7),
        .OVERFLOW(ovf7), .OVF_CLR(1'b0), .TX_BUSY(busy7), .RX(tx7), .TX(tx7)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive bits[0..n-1] onto RX, 16 clocks each, then return the line to idle.
    task automatic send_rx(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            wait_clk(16);
        end
        rx_drv = 1'b1;
    endtask

    task automatic pop8();
        if8.RX_READY = 1'b1;
        @(negedge clk);
        if8.RX_READY = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] obs;
        logic [15:0] fb;
        int          busy_cnt;

        rst = 1'b1; baud = 13'd0; pen = 1'b0; odd = 1'b0; stop2 = 1'b0;
        ovf_clr = 1'b0; rx_drv = 1'b1;
        if8.TX_VALID = 1'b0; if8.TX_DATA = '0; if8.RX_READY = 1'b0;
        if7.TX_VALID = 1'b0; if7.TX_DATA = '0; if7.RX_READY = 1'b0;
        wait_clk(3);
        chk("rst_tx", tx8, 1);
        chk("rst_tx_ready", if8.TX_READY, 1);
        chk("rst_rx_valid", if8.RX_VALID, 0);
        chk("rst_rx_data", {if8.RX_FERR, if8.RX_PERR, if8.RX_DATA}, 0);
        chk("rst_levels", {tx_lvl8, rx_lvl8}, 0);
        chk("rst_ovf_busy", {ovf8, busy8}, 0);
        rst = 1'b0;
        wait_clk(2);

        // 8N1 frame of 0xA5, checked at every bit centre
        if8.TX_DATA = 8'hA5; if8.TX_VALID = 1'b1;
        @(negedge clk);
        if8.TX_VALID = 1'b0;
        chk("tx_pre_start", tx8, 1);
        @(negedge clk);
        chk("tx_start_lat", tx8, 0);
        obs = '0; busy_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (k < 160 && k % 16 == 8) obs[k/16] = tx8;
            if (busy8) busy_cnt++;
            @(negedge clk);
        end
        chk("tx_frame_a5", obs, {6'b0, 1'b1, 8'hA5, 1'b0});
        chk("tx_busy_len", busy_cnt, 160);

        // 7-bit odd-parity loopback
        if7.TX_DATA = 7'h3C; if7.TX_VALID = 1'b1;
        @(negedge clk);
        if7.TX_VALID = 1'b0;
        for (int i = 0; i < 400 && !if7.RX_VALID; i++) @(negedge clk);
        chk("lp_valid", if7.RX_VALID, 1);
        chk("lp_data", if7.RX_DATA, 7'h3C);
        chk("lp_flags", {if7.RX_FERR, if7.RX_PERR}, 0);
        chk("lp_level", rx_lvl7, 1);
        wait_clk(40);

        // even parity, 0x01 with parity bit 0 (should be 1)
        pen = 1'b1; odd = 1'b0;
        send_rx({5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11);
        wait_clk(2);
        chk("perr_flag", if8.RX_PERR, 1);
        chk("perr_data", if8.RX_DATA, 8'h01);
        chk("perr_ferr", if8.RX_FERR, 0);
        pop8();
        pen = 1'b0;

        // stop bit 0 -> framing error
        send_rx({6'b0, 1'b0, 8'h55, 1'b0}, 10);
        wait_clk(2);
        chk("ferr_flag", {if8.RX_FERR, if8.RX_PERR}, 2'b10);
        chk("ferr_data", if8.RX_DATA, 8'h55);
        pop8();

        // line held low for 40 bit times -> one entry, then re-arm once high
        rx_drv = 1'b0;
        wait_clk(640);
        rx_drv = 1'b1;
        wait_clk(4);
        chk("brk_level", rx_lvl8, 1);
        chk("brk_entry", {if8.RX_FERR, if8.RX_DATA}, {1'b1, 8'h00});
        pop8();
        wait_clk(32);
        send_rx({6'b0, 1'b1, 8'h12, 1'b0}, 10);
        wait_clk(2);
        chk("rearm_entry", {if8.RX_FERR, if8.RX_PERR, if8.RX_DATA}, {2'b00, 8'h12});
        pop8();

        // five frames into a depth-4 RX FIFO with no reads
        for (int i = 1; i <= 5; i++) begin
            fb = {6'b0, 1'b1, 8'(i), 1'b0};
            send_rx(fb, 10);
        end
        wait_clk(2);
        chk("ovf_level", rx_lvl8, 4);
        chk("ovf_flag", ovf8, 1);
        chk("ovf_head", if8.RX_DATA, 8'h01);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf8, 0);
        pop8(); pop8(); pop8();
        chk("ovf_last", {rx_lvl8, if8.RX_DATA}, {3'd1, 8'h04});
        pop8();
        chk("ovf_empty", {rx_lvl8, if8.RX_VALID}, 0);

        // six writes on consecutive cycles, 2 stop bits: 5 frames back-to-back, 6th refused
        stop2 = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if8.TX_DATA = 8'(8'hA0 + i);
                    if8.TX_VALID = 1'b1;
                    @(negedge clk);
                end
                if8.TX_VALID = 1'b0;
                chk("txf_ready", if8.TX_READY, 0);
                chk("txf_level", tx_lvl8, 4);
            end
            begin
                logic [10:0] fr [5];
                logic [10:0] exp11;
                int          w;
                int          bc;
                int          late_low;
                w = 0;
                while (tx8 !== 1'b0 && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                chk("txf_start_seen", tx8, 0);
                bc = 0; late_low = 0;
                for (int f = 0; f < 5; f++) fr[f] = '0;
                for (int k = 0; k < 920; k++) begin
                    if (k < 880 && k % 16 == 8) fr[k/176][(k%176)/16] = tx8;
                    if (busy8) bc++;
                    if (k >= 880 && !tx8) late_low++;
                    @(negedge clk);
                end
                for (int f = 0; f < 5; f++) begin
                    exp11 = {2'b11, 8'(8'hA0 + f), 1'b0};
                    chk($sformatf("txf_frame%0d", f), fr[f], exp11);
                end
                chk("txf_busy_len", bc, 880);
                chk("txf_no_sixth", late_low, 0);
            end
        join
        stop2 = 1'b0;

        // reset in the middle of a data bit
        if8.TX_DATA = 8'h00; if8.TX_VALID = 1'b1;
        @(negedge clk);
        if8.TX_DATA = 8'h3C;
        @(negedge clk);
        if8.TX_VALID = 1'b0;
        wait_clk(40);
        chk("mid_tx_low", tx8, 0);
        chk("mid_tx_level", tx_lvl8, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_state", {tx8, busy8, tx_lvl8}, {1'b1, 1'b0, 3'd0});
        wait_clk(40);
        chk("mid_rst_idle", {tx8, busy8}, 2'b10);

        // short glitch on RX -> false start, no entry
        rx_drv = 1'b0;
        wait_clk(4);
        rx_drv = 1'b1;
        wait_clk(100);
        chk("glitch_none", {if8.RX_VALID, rx_lvl8}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
